// File: rtl/mult_seq_ctrl.sv
// Sequential N x N unsigned multiplier controller. One N x M partial product
// is folded into a 2N-bit accumulator per cycle over CC cycles, with a
// start/busy/done handshake around it.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; o/o_hi hold the last result
// S_RUN  | accumulating one slice of the multiplier per cycle (busy)
// S_DONE | one-cycle done pulse; o/o_hi already carry the new result
module mult_seq_ctrl #(
    parameter int N  = 128,
    parameter int CC = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] g_input,
    input  logic [N-1:0] e_input,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] o,
    output logic [N-1:0] o_hi
);

    localparam int M  = N / CC;
    localparam int KW = (CC > 1) ? $clog2(CC) : 1;
    localparam int W2 = 2 * N;
    localparam int SW = $clog2(2 * N) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            load;
    logic            last;

    logic [N-1:0]    a_r;
    logic [N-1:0]    b_r;
    logic [W2-1:0]   acc;
    logic [KW-1:0]   k;

    logic [N+M-1:0]  pp;
    logic [W2-1:0]   pp_ext;
    logic [SW-1:0]   sh;
    logic [W2-1:0]   acc_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a start in DONE re-captures directly into RUN
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);
    assign last = (k == KW'(CC - 1));

    // Partial product of the current multiplier slice, placed at slice k
    always_comb begin
        pp      = {{M{1'b0}}, a_r} * {{N{1'b0}}, b_r[M-1:0]};
        pp_ext  = W2'(pp);
        sh      = SW'(k) * SW'(M);
        acc_nxt = acc + (pp_ext << sh);
    end

    // Datapath; the result registers load on the final RUN edge so they are
    // already valid while done is high
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r  <= '0;
            b_r  <= '0;
            acc  <= '0;
            k    <= '0;
            o    <= '0;
            o_hi <= '0;
        end else if (load) begin
            a_r <= g_input;
            b_r <= e_input;
            acc <= '0;
            k   <= '0;
        end else if (state == S_RUN) begin
            acc <= acc_nxt;
            b_r <= b_r >> M;
            k   <= k + KW'(1);
            if (last) begin
                o    <= acc_nxt[N-1:0];
                o_hi <= acc_nxt[W2-1:N];
            end
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: three configurations (N=8/CC=4, N=16/CC=1,
// N=32/CC=8) share one clock and reset; directed cases plus random vectors
// checked against a plain-arithmetic product model.
module tb_mult_seq_ctrl;

    logic clk;
    logic rst;

    logic        start_v [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        done_prev [3];
    logic [31:0] o_w  [3];
    logic [31:0] oh_w [3];

    logic [7:0]  g8,  e8,  o8,  oh8;
    logic [15:0] g16, e16, o16, oh16;
    logic [31:0] g32, e32, o32, oh32;

    int n_cmp;
    int n_bad;

    localparam int NS  [3] = '{8, 16, 32};
    localparam int CCS [3] = '{4, 1, 8};

    mult_seq_ctrl #(.N(8), .CC(4)) u_d8 (
        .clk(clk), .rst(rst), .start(start_v[0]),
        .g_input(g8), .e_input(e8),
        .busy(busy_v[0]), .done(done_v[0]), .o(o8), .o_hi(oh8)
    );

    mult_seq_ctrl #(.N(16), .CC(1)) u_d16 (
        .clk(clk), .rst(rst), .start(start_v[1]),
        .g_input(g16), .e_input(e16),
        .busy(busy_v[1]), .done(done_v[1]), .o(o16), .o_hi(oh16)
    );

    mult_seq_ctrl #(.N(32), .CC(8)) u_d32 (
        .clk(clk), .rst(rst), .start(start_v[2]),
        .g_input(g32), .e_input(e32),
        .busy(busy_v[2]), .done(done_v[2]), .o(o32), .o_hi(oh32)
    );

    assign o_w[0]  = {24'd0, o8};
    assign oh_w[0] = {24'd0, oh8};
    assign o_w[1]  = {16'd0, o16};
    assign oh_w[1] = {16'd0, oh16};
    assign o_w[2]  = o32;
    assign oh_w[2] = oh32;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int idx, input logic [31:0] a, input logic [31:0] b);
        case (idx)
            0: begin g8  = a[7:0];  e8  = b[7:0];  end
            1: begin g16 = a[15:0]; e16 = b[15:0]; end
            default: begin g32 = a; e32 = b; end
        endcase
    endtask

    function automatic logic [63:0] mask_n(input int n);
        return (64'd1 << n) - 64'd1;
    endfunction

    // Reference: full-width product split into low/high halves
    task automatic ref_prod(input int idx, input logic [31:0] a, input logic [31:0] b,
                            output logic [63:0] lo, output logic [63:0] hi);
        logic [63:0] p;
        int n;
        n  = NS[idx];
        p  = (64'(a) & mask_n(n)) * (64'(b) & mask_n(n));
        lo = p & mask_n(n);
        hi = (p >> n) & mask_n(n);
    endtask

    // One complete operation from IDLE, checking busy/done every cycle and
    // the result in the done cycle; operands are scrambled during RUN
    task automatic run_check(input int idx, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] lo, hi;
        int cc;
        cc = CCS[idx];
        ref_prod(idx, a, b, lo, hi);
        @(negedge clk);
        drive(idx, a, b);
        start_v[idx] = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= cc + 1; j++) begin
            @(negedge clk);
            if (j == 1) begin
                start_v[idx] = 1'b0;
                drive(idx, $urandom, $urandom);
            end
            chk("busy", 64'(busy_v[idx]), 64'(j <= cc));
            chk("done", 64'(done_v[idx]), 64'(j == cc + 1));
            if (j == cc + 1) begin
                chk("o", 64'(o_w[idx]), lo);
                chk("o_hi", 64'(oh_w[idx]), hi);
            end
        end
    endtask

    // done must never stay high two cycles in a row
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done_v[i]) chk("done_twice", 64'(done_prev[i]), 64'd0);
            done_prev[i] <= done_v[i];
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        int done_at;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_v[i]   = 1'b0;
            done_prev[i] = 1'b0;
        end
        drive(0, 0, 0);
        drive(1, 0, 0);
        drive(2, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", 64'(busy_v[i]), 64'd0);
            chk("rst_done", 64'(done_v[i]), 64'd0);
            chk("rst_o", 64'(o_w[i]), 64'd0);
            chk("rst_o_hi", 64'(oh_w[i]), 64'd0);
        end

        // basic 0xFF x 0xFF
        run_check(0, 32'hFF, 32'hFF);
        chk("basic_o", 64'(o_w[0]), 64'h01);
        chk("basic_o_hi", 64'(oh_w[0]), 64'hFE);

        // start during RUN is ignored
        @(negedge clk);
        drive(0, 32'h12, 32'h34);
        start_v[0] = 1'b1;
        @(posedge clk);
        ndone   = 0;
        done_at = -1;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (done_v[0]) begin
                ndone++;
                done_at = j;
            end
            if (j == 5) chk("ign_result", {32'd0, oh_w[0][7:0], o_w[0][7:0]}, 64'h03A8);
            if (j == 1) start_v[0] = 1'b0;
            if (j == 2) begin
                drive(0, 32'hFF, 32'hFF);
                start_v[0] = 1'b1;
            end
            if (j == 3) start_v[0] = 1'b0;
        end
        chk("ign_ndone", 64'(ndone), 64'd1);
        chk("ign_done_at", 64'(done_at), 64'd5);
        chk("ign_busy_after", 64'(busy_v[0]), 64'd0);

        // reset in cycle 3 of a RUN, with a start in the reset cycle
        @(negedge clk);
        drive(0, 32'h55, 32'h66);
        start_v[0] = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            if (j == 1) start_v[0] = 1'b0;
            if (j == 3) begin
                rst = 1'b1;
                start_v[0] = 1'b1;
            end
        end
        @(negedge clk);
        chk("rmid_busy", 64'(busy_v[0]), 64'd0);
        chk("rmid_done", 64'(done_v[0]), 64'd0);
        chk("rmid_o", 64'(o_w[0]), 64'd0);
        chk("rmid_o_hi", 64'(oh_w[0]), 64'd0);
        rst = 1'b0;
        start_v[0] = 1'b0;
        ndone = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (done_v[0]) ndone++;
        end
        chk("rmid_no_done", 64'(ndone), 64'd0);
        run_check(0, 32'd3, 32'd5);
        chk("rmid_fresh_o", 64'(o_w[0]), 64'h0F);
        chk("rmid_fresh_o_hi", 64'(oh_w[0]), 64'h00);

        // back-to-back with start held high
        @(negedge clk);
        drive(0, 32'd7, 32'd9);
        start_v[0] = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            chk("b2b_done", 64'(done_v[0]), 64'((j == 5) || (j == 10)));
            if (j == 1) drive(0, 32'h80, 32'h02);
            if (j == 5) chk("b2b_o_hi1", 64'(oh_w[0]), 64'h00);
            if (j >= 5 && j <= 9) chk("b2b_o_hold", 64'(o_w[0]), 64'h3F);
            if (j == 10) begin
                chk("b2b_o2", 64'(o_w[0]), 64'h00);
                chk("b2b_o_hi2", 64'(oh_w[0]), 64'h01);
            end
            if (j == 6) start_v[0] = 1'b0;
        end

        // edge operands
        run_check(0, 32'h00, 32'hFF);
        run_check(0, 32'h01, 32'hAB);
        chk("edge_o", 64'(o_w[0]), 64'hAB);
        chk("edge_o_hi", 64'(oh_w[0]), 64'h00);

        // CC=1
        run_check(1, 32'hFFFF, 32'h0002);
        chk("cc1_o", 64'(o_w[1]), 64'hFFFE);
        chk("cc1_o_hi", 64'(oh_w[1]), 64'h0001);

        // random vectors on every configuration
        for (int idx = 0; idx < 3; idx++) begin
            for (int v = 0; v < 1000; v++) begin
                run_check(idx, $urandom, $urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
